data_line_memory: RTL and testbench
===================================

# data_line_memory

Off-chip data memory model that sits directly downstream of the CPU's data cache on its 256-bit line interface. It accepts one line read or line write per request and answers with a single-cycle acknowledge after a fixed, parameterised latency. It stores lines in an internal array indexed by the line address. The dcache's line-fill and write-back state machine depends on this latency to exercise its stall path.

## Interface
- `LINE_W`, default 256: line width in bits.
- `DEPTH`, default 512: number of stored lines; must be a power of two.
- `LATENCY`, default 10: cycles from request accept to ack; must be ≥ 1.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: asynchronous, active-low reset.
- `enable_i`  in  1: request valid; the cache holds it high until it sees `ack_o`.
- `write_i`  in  1: 1 = line write, 0 = line read; sampled with `enable_i`.
- `addr_i`  in  32: byte address.
- `data_i`  in  LINE_W: write line.
- `ack_o`  out  1: request complete; high for exactly one cycle.
- `data_o`  out  LINE_W: read line; valid while `ack_o` is high.

## Operation
- States: IDLE, WAIT, ACK.
- **IDLE**
  - When `enable_i` = 1 at an edge: latch `write_i`, the line index, and `data_i`.
  - Load the counter with LATENCY-1, then go to WAIT.
- **WAIT**
  - Decrement the counter each edge.
  - Take no action on any input; the latched request is used.
  - When the counter is 0 at an edge, perform the access and go to ACK:
    - Read: `data_o` ← array[index].
    - Write: array[index] ← latched data; `data_o` holds its previous value.
- **ACK**
  - `ack_o` = 1 for this cycle only.
  - Next edge: go to IDLE unconditionally.
  - `enable_i` sampled at this edge is ignored, because the cache has not yet reacted to the ack.
- **Line index:** `addr_i[5 +: log2(DEPTH)]`.
  - `addr_i[4:0]` (byte offset within the line) is ignored.
  - Address bits above the index are ignored, so addresses wrap modulo DEPTH lines.
- **Reset (`rst_i` low, any time)**
  - State → IDLE, counter → 0, `ack_o` → 0, `data_o` → 0.
  - An in-flight write is dropped, with no array update.
- Array contents are not cleared by reset; the bench preloads them.

## Timing
- Request accepted at edge E0.
- The access is performed at edge E0+LATENCY.
- `ack_o` and `data_o` are registered outputs, valid in the cycle after edge E0+LATENCY.
- Earliest next accept is edge E0+LATENCY+2, giving a request period of LATENCY+2 cycles.
- With LATENCY = 1, WAIT lasts exactly one cycle: the counter is loaded to 0 and the access happens at the next edge.
- Counter width is `$clog2(LATENCY)`, minimum 1.
- There is no combinational path from any input to any output.

## Structure
- Package `data_mem_pkg` holds:
  - the state enum (IDLE/WAIT/ACK),
  - the `LINE_OFFSET_BITS` = 5 constant,
  - the default `LINE_W`.
- Sub-module `line_ram` holds the storage:
  - single port, synchronous, with write enable, index, write data, and registered read data;
  - instantiated once.
- The FSM and counter live in the top module.

## Test plan
1. **Reset:** hold `rst_i` low for 3 cycles with `enable_i` = 1 → `ack_o` = 0 and `data_o` = 0 throughout, and no array change.
2. **Write then read:** write 256'hA5…A5 to 0x400, accepted at E0 → `ack_o` high in exactly the cycle after E0+10. Then read 0x400 → `data_o` = 256'hA5…A5 with `ack_o`.
3. **Offset and wrap:** read 0x41F and 0x400+512·32 → same line as 0x400.
4. **Back-to-back:** hold `enable_i` high across two reads (0x000 then 0x020) → two acks exactly 12 cycles apart, each carrying the correct line. The held request is not re-accepted in the ACK cycle.
5. **Inputs ignored in WAIT:** change `addr_i`, `write_i` and `data_i` during WAIT → the access uses the values latched at E0.
6. **Reset mid-write:** assert reset 4 cycles into a write to 0x800 → no ack. A subsequent read of 0x800 returns the preloaded contents.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data line memory model.
//   state_e          : request FSM states (IDLE / WAIT / ACK)
//   LINE_OFFSET_BITS : byte-offset bits inside a 32-byte line
//   LINE_W_DEF       : default line width in bits
package data_mem_pkg;

  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned LINE_W_DEF       = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/data_line_memory_if.sv
// data_line_memory_if: dcache <-> line memory request/ack bus.
//   enable_i : request valid, held until ack_o is seen
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address
//   data_i   : write line
//   ack_o    : one-cycle completion pulse
//   data_o   : read line, valid with ack_o
interface data_line_memory_if
  import data_mem_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/line_ram.sv
// line_ram: single-port synchronous line storage.
//   clk_i, rst_i : clock, async active-low reset (read register only)
//   en, we       : access strobe and write select
//   idx          : line index
//   wdata        : write line
//   rdata        : registered read line; holds on writes and idle cycles
module line_ram #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage is never cleared by reset; contents survive it.
  always_ff @(posedge clk_i) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, updated only by reads.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_line_memory.sv
// data_line_memory: fixed-latency line memory downstream of the dcache.
//   clk_i : clock, rising edge
//   rst_i : async active-low reset
//   bus   : request/ack bus (slave side)
// A request is latched in IDLE, waits LATENCY edges in WAIT, is performed
// on the last WAIT edge, and is acknowledged for one cycle in ACK.
module data_line_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_line_memory_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ack_q;
  logic              load_c;
  logic              access_c;

  // Byte offset and bits above the index do not select a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:LINE_OFFSET_BITS+IDX_W],
                              bus.addr_i[LINE_OFFSET_BITS-1:0]};

  // State, counter and latched request registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= access_c;
      if (load_c) begin
        write_q <= bus.write_i;
        idx_q   <= bus.addr_i[LINE_OFFSET_BITS +: IDX_W];
        wdata_q <= bus.data_i;
      end
    end
  end

  // Next-state: inputs are only looked at in IDLE; ACK always returns to
  // IDLE so a still-held enable is not taken as a new request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_c   = 1'b0;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          load_c  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  line_ram #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (access_c),
    .we    (write_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (bus.data_o)
  );

  assign bus.ack_o = ack_q;

endmodule

// File: tb/tb_data_line_memory.sv
// tb_data_line_memory: randomized self-checking bench for data_line_memory.
// A schedule-level model (accept at first idle edge with enable, access
// LATENCY edges later, next accept LATENCY+2 edges after the last) predicts
// ack_o and data_o, which are compared on every falling edge.
module tb_data_line_memory;
  import data_mem_pkg::*;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned LATENCY = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_line_memory_if #(.LINE_W(LINE_W)) bus ();

  data_line_memory #(
    .LINE_W  (LINE_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [LINE_W-1:0] mem_m [DEPTH];
  int                cyc        = 0;
  bit                pend       = 1'b0;
  int                acc_edge   = 0;
  int                busy_until = 0;
  bit                p_write    = 1'b0;
  int unsigned       p_idx      = 0;
  logic [LINE_W-1:0] p_data     = '0;
  bit                exp_ack    = 1'b0;
  logic [LINE_W-1:0] exp_data   = '0;
  int                n_acks     = 0;

  function automatic int unsigned idx_of(logic [31:0] a);
    return (a / 32) % DEPTH;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_line(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: evaluated at each rising edge, cleared by reset at any time.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend       = 1'b0;
        exp_ack    = 1'b0;
        exp_data   = '0;
        busy_until = 0;
      end else begin
        cyc++;
        exp_ack = 1'b0;
        if (pend && cyc == acc_edge) begin
          pend    = 1'b0;
          exp_ack = 1'b1;
          if (p_write) mem_m[p_idx] = p_data;
          else         exp_data = mem_m[p_idx];
        end
        if (!pend && bus.enable_i && cyc >= busy_until) begin
          pend       = 1'b1;
          acc_edge   = cyc + int'(LATENCY);
          busy_until = cyc + int'(LATENCY) + 2;
          p_write    = bus.write_i;
          p_idx      = idx_of(bus.addr_i);
          p_data     = bus.data_i;
        end
      end
    end
  end

  // Compare on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check_int("ack_o", int'(bus.ack_o), int'(exp_ack));
      check_line("data_o", bus.data_o, exp_data);
      if (bus.ack_o) n_acks++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue a request and hold it until ack; returns the edge count of the ack.
  task automatic req(input bit w, input logic [31:0] a, input logic [LINE_W-1:0] d,
                     input bit hold, input bit scramble, output int ack_cyc);
    bus.enable_i = 1'b1;
    bus.write_i  = w;
    bus.addr_i   = a;
    bus.data_i   = d;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (scramble && i == 3) begin
        bus.addr_i  = $urandom;
        bus.write_i = ~w;
        bus.data_i  = rand_line();
      end
      if (bus.ack_o) begin
        ack_cyc = cyc;
        if (!hold) bus.enable_i = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack after 60 cycles, expected one");
    bus.enable_i = 1'b0;
    ack_cyc = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_3C = {32{8'h3C}};

  initial begin
    int t0, a1, a2, acks0;
    logic [LINE_W-1:0] pre800;
    int unsigned lines [10];

    // Reset with a request pending: nothing may happen.
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h400;
    bus.data_i   = '1;
    repeat (3) tick();
    check_int("reset_no_ack", n_acks, 0);
    bus.enable_i = 1'b0;
    rst_n = 1'b1;
    tick();

    // Preload the lines the bench reads.
    for (int i = 0; i < 8; i++) lines[i] = i;
    lines[8] = 32;
    lines[9] = 64;
    for (int i = 0; i < 10; i++) req(1'b1, lines[i] * 32, rand_line(), 1'b0, 1'b0, a1);
    pre800 = mem_m[64];

    // Write then read, with exact latency.
    tick();
    t0 = cyc;
    req(1'b1, 32'h400, PAT_A5, 1'b0, 1'b0, a1);
    check_int("wr_latency", a1 - t0, 11);
    tick();
    t0 = cyc;
    req(1'b0, 32'h400, '0, 1'b0, 1'b0, a1);
    check_int("rd_latency", a1 - t0, 11);
    check_line("rd_0x400", bus.data_o, PAT_A5);

    // Byte offset and wrap select the same line.
    req(1'b0, 32'h41F, '0, 1'b0, 1'b0, a1);
    check_line("rd_0x41F", bus.data_o, PAT_A5);
    req(1'b0, 32'h400 + DEPTH * 32, '0, 1'b0, 1'b0, a1);
    check_line("rd_wrap", bus.data_o, PAT_A5);

    // Back-to-back reads with enable held through the ack.
    tick();
    acks0 = n_acks;
    req(1'b0, 32'h000, '0, 1'b1, 1'b0, a1);
    req(1'b0, 32'h020, '0, 1'b0, 1'b0, a2);
    check_int("b2b_spacing", a2 - a1, 12);
    tick();
    check_int("b2b_ack_count", n_acks - acks0, 2);

    // Inputs changed during WAIT are ignored.
    tick();
    req(1'b1, 32'h060, PAT_3C, 1'b0, 1'b1, a1);
    tick();
    req(1'b0, 32'h060, '0, 1'b0, 1'b0, a1);
    check_line("wait_ignore", bus.data_o, PAT_3C);

    // Reset four cycles into a write drops it.
    tick();
    acks0 = n_acks;
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h800;
    bus.data_i   = ~pre800;
    tick();
    repeat (4) tick();
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check_int("rst_mid_no_ack", n_acks - acks0, 0);
    req(1'b0, 32'h800, '0, 1'b0, 1'b0, a1);
    check_line("rst_mid_keep", bus.data_o, pre800);

    // Reset with a held write request leaves the array unchanged.
    tick();
    rst_n = 1'b0;
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h400;
    bus.data_i   = '0;
    repeat (3) tick();
    bus.enable_i = 1'b0;
    rst_n = 1'b1;
    tick();
    req(1'b0, 32'h400, '0, 1'b0, 1'b0, a1);
    check_line("rst_no_write", bus.data_o, PAT_A5);

    // Randomized traffic over the preloaded lines.
    for (int n = 0; n < 40; n++) begin
      int unsigned li;
      logic [31:0] a;
      li = lines[$urandom_range(0, 9)];
      a  = li * 32 + $urandom_range(0, 31) + $urandom_range(0, 7) * DEPTH * 32;
      req(1'($urandom_range(0, 1)), a, rand_line(), (n != 39) && ($urandom_range(0, 1) == 1),
          1'b0, a1);
      if ($urandom_range(0, 2) == 0) tick();
    end
    bus.enable_i = 1'b0;
    repeat (15) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
